// File: rtl/axi_rx_capture_ctrl.sv
// Purpose: sequences one RX capture. It arms the deserializer, buffers word strobes in an
//          elastic FIFO and frames them into AXI-Stream packets with tlast.
// Latency: a strobe into an empty FIFO appears on m_tvalid one aclk cycle later.
// Backpressure: m_tready stalls the FIFO head. The deserializer does not honour s_ready,
//               so a strobe that arrives while the FIFO is full is dropped and flagged.
//
// Ports:
//   aclk, aresetn             clock, async active-low reset
//   cmd_start, cmd_stop       single-cycle capture control pulses
//   cfg_frame_len             words per frame (0 acts as 1), latched at arm
//   cfg_num_frames            frames per capture (0 = continuous), latched at arm
//   cfg_timeout               inactivity limit in cycles (0 = off), latched at arm
//   rx_enable                 deserializer enable, high only while capturing
//   s_data, s_valid, s_ready  deserializer word strobe; s_ready is FIFO-not-full
//   m_tdata/m_tvalid/m_tlast/m_tready  AXI-Stream master
//   busy, done, timeout_err, overflow_err, trunc_err, frame_count  status

// Purpose: generic synchronous FIFO with a combinational read port (head always visible).
// Latency: a word written at edge n is readable right after edge n.
// Backpressure: the caller must not write when full unless it reads in the same cycle.
module rx_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign rd_dat = mem[rd_ptr];

  // Storage carries no reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module axi_rx_capture_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int LEN_W  = 8,
  parameter int FRM_W  = 16,
  parameter int TMO_W  = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic [LEN_W-1:0]  cfg_frame_len,
  input  logic [FRM_W-1:0]  cfg_num_frames,
  input  logic [TMO_W-1:0]  cfg_timeout,
  output logic              rx_enable,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              overflow_err,
  output logic              trunc_err,
  output logic [FRM_W-1:0]  frame_count
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t state;

  // Configuration captured at arm, so mid-capture cfg changes have no effect.
  logic [LEN_W-1:0] len_q;
  logic [FRM_W-1:0] num_q;
  logic [TMO_W-1:0] tmo_q;

  logic [LEN_W-1:0] word_in_frame;
  logic [TMO_W-1:0] idle_cnt;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_rd;
  logic              pop;
  logic              push_try;
  logic              push_ok;
  logic              at_last;
  logic [FRM_W-1:0]  fc_inc;
  logic [TMO_W-1:0]  idle_inc;
  logic              complete;
  logic              tmo_hit;

  assign m_tvalid = !fifo_empty;
  assign pop      = m_tvalid && m_tready;
  assign s_ready  = !fifo_full;

  // Head is gated so an empty FIFO presents all-zero data and tlast.
  assign m_tdata  = m_tvalid ? fifo_rd[DATA_W-1:0] : '0;
  assign m_tlast  = m_tvalid && fifo_rd[DATA_W];

  assign push_try = (state == S_RUN) && s_valid;
  // When full, a same-cycle pop frees the slot that the push then occupies.
  assign push_ok  = push_try && (!fifo_full || pop);

  // len_q is never zero, so len_q-1 cannot wrap.
  assign at_last  = (word_in_frame == (len_q - LEN_W'(1)));
  assign fc_inc   = (frame_count == '1) ? frame_count : frame_count + FRM_W'(1);
  assign idle_inc = (idle_cnt == '1) ? idle_cnt : idle_cnt + TMO_W'(1);

  // A frame position is consumed even when its word is dropped, so completion
  // depends only on the strobe, not on whether the push succeeded.
  assign complete = push_try && at_last && (num_q != '0) && (fc_inc == num_q);
  // Fires on the idle cycle whose increment reaches the limit.
  assign tmo_hit  = (tmo_q != '0) && !s_valid && (idle_inc == tmo_q);

  rx_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (aclk),
    .rst_n  (aresetn),
    .wr_en  (push_ok),
    .wr_dat ({at_last, s_data}),
    .rd_en  (pop),
    .rd_dat (fifo_rd),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= S_IDLE;
      rx_enable     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
      overflow_err  <= 1'b0;
      trunc_err     <= 1'b0;
      frame_count   <= '0;
      word_in_frame <= '0;
      idle_cnt      <= '0;
      len_q         <= LEN_W'(1);
      num_q         <= '0;
      tmo_q         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // A start that collides with a stop is treated as cancelled.
          if (cmd_start && !cmd_stop) begin
            state <= S_ARM;
            busy  <= 1'b1;
          end
        end

        S_ARM: begin
          len_q         <= (cfg_frame_len == '0) ? LEN_W'(1) : cfg_frame_len;
          num_q         <= cfg_num_frames;
          tmo_q         <= cfg_timeout;
          done          <= 1'b0;
          timeout_err   <= 1'b0;
          overflow_err  <= 1'b0;
          trunc_err     <= 1'b0;
          frame_count   <= '0;
          word_in_frame <= '0;
          idle_cnt      <= '0;
          rx_enable     <= 1'b1;
          state         <= S_RUN;
        end

        S_RUN: begin
          if (push_try) begin
            if (!push_ok) begin
              overflow_err <= 1'b1;
            end
            if (at_last) begin
              word_in_frame <= '0;
              frame_count   <= fc_inc;
            end else begin
              word_in_frame <= word_in_frame + LEN_W'(1);
            end
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_inc;
          end

          // Completion outranks stop, which outranks timeout.
          if (complete) begin
            state     <= S_DRAIN;
            rx_enable <= 1'b0;
          end else if (cmd_stop) begin
            state     <= S_DRAIN;
            rx_enable <= 1'b0;
            if (word_in_frame != '0) begin
              trunc_err <= 1'b1;
            end
          end else if (tmo_hit) begin
            state       <= S_DRAIN;
            rx_enable   <= 1'b0;
            timeout_err <= 1'b1;
            if (word_in_frame != '0) begin
              trunc_err <= 1'b1;
            end
          end
        end

        S_DRAIN: begin
          if (fifo_empty) begin
            if (!timeout_err) begin
              done <= 1'b1;
            end
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          rx_enable <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule
